lfsr_arbiter: RTL and testbench

Shared-access controller for the team's 8-bit pseudo-random number generator. It owns one LFSR state register, accepts a tap/seed configuration, and hands successive LFSR values to up to N_REQ requesters under round-robin arbitration. Each grant returns one value and advances the LFSR by one step. It also measures and reports the sequence period. It sits between the LFSR datapath and the blocks that need cheap, multiplier-free random numbers.

---
 rtl/lfsr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_lfsr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: one 8-bit LFSR shared among N_REQ requesters.
// Round-robin arbitration picks one requester per cycle. The winner gets
// the current LFSR value, and the LFSR then advances by one step.
// The block also measures the number of steps from the seed back to the seed.
module lfsr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = 16
) (
    input  logic              in_clk,
    input  logic              in_n_rst,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_taps,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic [DATA_W-1:0] rnd_data,
    output logic              rnd_valid,
    output logic              configured,
    output logic              seed_err,
    output logic              wrap,
    output logic [CNT_W-1:0]  period_len
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   lfsr_q, lfsr_d;
    logic [DATA_W-1:0]   taps_q, taps_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic [N_REQ-1:0]    grant_d;
    logic [DATA_W-1:0]   rnd_data_d;
    logic                rnd_valid_d;
    logic                configured_d;
    logic                seed_err_d;
    logic                wrap_d;
    logic [CNT_W-1:0]    period_d;

    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    cand;
    logic [DATA_W-1:0]   lfsr_next;
    logic [CNT_W-1:0]    cnt_inc;

    // One LFSR step. The value shifts right, and v[0] always feeds back.
    // Tap bit k adds v[7-k] to the feedback. Tap bit 7 is not used.
    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v,
                                                    input logic [DATA_W-1:0] t);
        logic fb;
        fb = v[0];
        for (int k = 0; k < DATA_W - 1; k++) begin
            fb = fb ^ (t[k] & v[DATA_W-1-k]);
        end
        return {fb, v[DATA_W-1:1]};
    endfunction

    // Round-robin pick: find the first set request, searching upward from ptr with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next LFSR value and the step count that saturates at its maximum.
    always_comb begin
        lfsr_next = lfsr_step(lfsr_q, taps_q);
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and registered-output logic. Configuration takes priority over arbitration.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        taps_d       = taps_q;
        seed_d       = seed_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        grant_d      = '0;
        rnd_data_d   = rnd_data;
        rnd_valid_d  = 1'b0;
        configured_d = configured;
        seed_err_d   = 1'b0;
        wrap_d       = 1'b0;
        period_d     = period_len;

        if (cfg_valid) begin
            if (cfg_seed == '0) begin
                // An all-zero seed would lock the LFSR at zero, so it is rejected.
                seed_err_d = 1'b1;
            end else begin
                taps_d       = cfg_taps;
                seed_d       = cfg_seed;
                lfsr_d       = cfg_seed;
                cnt_d        = '0;
                configured_d = 1'b1;
                state_d      = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_UNCFG: begin
                    // Requests are dropped until a seed has been loaded.
                end
                ST_RUN: begin
                    if (pick_found) begin
                        grant_d     = N_REQ'(1) << pick_idx;
                        ptr_d       = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                        rnd_data_d  = lfsr_q;
                        rnd_valid_d = 1'b1;
                        lfsr_d      = lfsr_next;
                        cnt_d       = cnt_inc;
                        if (lfsr_next == seed_q) begin
                            wrap_d   = 1'b1;
                            period_d = cnt_inc;
                            cnt_d    = '0;
                        end
                    end
                end
                default: state_d = ST_UNCFG;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge in_clk or negedge in_n_rst) begin
        if (!in_n_rst) begin
            state_q    <= ST_UNCFG;
            lfsr_q     <= '0;
            taps_q     <= '0;
            seed_q     <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant      <= '0;
            rnd_data   <= '0;
            rnd_valid  <= 1'b0;
            configured <= 1'b0;
            seed_err   <= 1'b0;
            wrap       <= 1'b0;
            period_len <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            taps_q     <= taps_d;
            seed_q     <= seed_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant      <= grant_d;
            rnd_data   <= rnd_data_d;
            rnd_valid  <= rnd_valid_d;
            configured <= configured_d;
            seed_err   <= seed_err_d;
            wrap       <= wrap_d;
            period_len <= period_d;
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed testbench for lfsr_arbiter. Expected values are worked out by hand
// for taps 0xB8, which makes the feedback v0^v2^v3^v4.
module tb_lfsr_arbiter;

    logic        in_clk;
    logic        in_n_rst;
    logic        cfg_valid;
    logic [7:0]  cfg_taps;
    logic [7:0]  cfg_seed;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        configured;
    logic        seed_err;
    logic        wrap;
    logic [15:0] period_len;

    int errors = 0;
    int checks = 0;

    lfsr_arbiter #(.N_REQ(4)) dut (
        .in_clk     (in_clk),
        .in_n_rst   (in_n_rst),
        .cfg_valid  (cfg_valid),
        .cfg_taps   (cfg_taps),
        .cfg_seed   (cfg_seed),
        .req        (req),
        .grant      (grant),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .configured (configured),
        .seed_err   (seed_err),
        .wrap       (wrap),
        .period_len (period_len)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        int n_grant;
        int n_wrap;
        int wrap_at;

        in_n_rst  = 1'b0;
        cfg_valid = 1'b0;
        cfg_taps  = 8'h00;
        cfg_seed  = 8'h00;
        req       = 4'b0000;
        tick();
        tick();
        check("rst_grant",      32'(grant),      32'h0);
        check("rst_rnd_valid",  32'(rnd_valid),  32'h0);
        check("rst_rnd_data",   32'(rnd_data),   32'h00);
        check("rst_configured", 32'(configured), 32'h0);
        check("rst_seed_err",   32'(seed_err),   32'h0);
        check("rst_wrap",       32'(wrap),       32'h0);
        check("rst_period_len", 32'(period_len), 32'h0);
        in_n_rst = 1'b1;
        tick();

        // A zero seed is rejected, and a held request is never granted while unconfigured.
        req       = 4'b0001;
        cfg_valid = 1'b1;
        cfg_taps  = 8'hB8;
        cfg_seed  = 8'h00;
        tick();
        check("zseed_err",      32'(seed_err),   32'h1);
        check("zseed_cfg",      32'(configured), 32'h0);
        check("zseed_grant",    32'(grant),      32'h0);
        cfg_valid = 1'b0;
        tick();
        check("zseed_err_pulse", 32'(seed_err), 32'h0);
        check("uncfg_grant0",    32'(grant),    32'h0);
        tick();
        check("uncfg_grant1",    32'(grant),    32'h0);
        check("uncfg_valid1",    32'(rnd_valid), 32'h0);

        // A seed of 0x01 is accepted, and grants start on the next cycle.
        cfg_valid = 1'b1;
        cfg_seed  = 8'h01;
        tick();
        check("seed01_cfg",   32'(configured), 32'h1);
        check("seed01_nogrant", 32'(grant),    32'h0);
        cfg_valid = 1'b0;
        tick();
        check("seed01_grant", 32'(grant),    32'h1);
        check("seed01_data",  32'(rnd_data), 32'h01);
        check("seed01_valid", 32'(rnd_valid), 32'h1);
        tick();
        check("seed01_data2", 32'(rnd_data), 32'h80);
        req = 4'b0000;
        tick();
        check("idle_grant",   32'(grant),     32'h0);
        check("idle_valid",   32'(rnd_valid), 32'h0);

        // Taps 0xB8 with seed 0xAA give the sequence AA, D5, EA, F5.
        req       = 4'b0001;
        cfg_valid = 1'b1;
        cfg_taps  = 8'hB8;
        cfg_seed  = 8'hAA;
        tick();
        check("aa_cfg_nogrant", 32'(grant), 32'h0);
        cfg_valid = 1'b0;
        tick();
        check("aa_g0", 32'(grant),    32'h1);
        check("aa_d0", 32'(rnd_data), 32'hAA);
        tick();
        check("aa_d1", 32'(rnd_data), 32'hD5);
        tick();
        check("aa_d2", 32'(rnd_data), 32'hEA);
        // ptr is now 1, so requester 3 wins, and ptr wraps back to 0.
        req = 4'b1000;
        tick();
        check("r3_grant", 32'(grant),    32'h8);
        check("r3_data",  32'(rnd_data), 32'hF5);

        // With all requesters active, grants rotate through each requester in turn.
        req = 4'b1111;
        tick();
        check("rr_g0", 32'(grant), 32'h1);
        check("rr_v0", 32'(rnd_valid), 32'h1);
        tick();
        check("rr_g1", 32'(grant), 32'h2);
        check("rr_v1", 32'(rnd_valid), 32'h1);
        tick();
        check("rr_g2", 32'(grant), 32'h4);
        check("rr_v2", 32'(rnd_valid), 32'h1);
        tick();
        check("rr_g3", 32'(grant), 32'h8);
        check("rr_v3", 32'(rnd_valid), 32'h1);
        tick();
        check("rr_g4", 32'(grant), 32'h1);
        check("rr_v4", 32'(rnd_valid), 32'h1);
        req = 4'b0000;
        tick();

        // Configuration wins over a pending request. ptr is 1 here.
        req       = 4'b0001;
        cfg_valid = 1'b1;
        cfg_seed  = 8'h55;
        tick();
        check("cfgpri_grant", 32'(grant),     32'h0);
        check("cfgpri_valid", 32'(rnd_valid), 32'h0);
        cfg_valid = 1'b0;
        tick();
        check("cfgpri_g", 32'(grant),    32'h1);
        check("cfgpri_d", 32'(rnd_data), 32'h55);
        req = 4'b1111;
        tick();
        check("ptr1_g", 32'(grant),    32'h2);
        check("ptr1_d", 32'(rnd_data), 32'hAA);
        // A configuration cycle leaves ptr at 2.
        cfg_valid = 1'b1;
        tick();
        check("cfgptr_nogrant", 32'(grant), 32'h0);
        cfg_valid = 1'b0;
        tick();
        check("cfgptr_g", 32'(grant),    32'h4);
        check("cfgptr_d", 32'(rnd_data), 32'h55);
        req = 4'b0000;
        tick();

        // In RUN, a zero seed is rejected and the taps and LFSR value stay as they were.
        req       = 4'b0001;
        cfg_valid = 1'b1;
        cfg_taps  = 8'h00;
        cfg_seed  = 8'h00;
        tick();
        check("runrej_err",   32'(seed_err),   32'h1);
        check("runrej_cfg",   32'(configured), 32'h1);
        check("runrej_grant", 32'(grant),      32'h0);
        cfg_valid = 1'b0;
        tick();
        check("runrej_err_pulse", 32'(seed_err), 32'h0);
        check("runrej_g", 32'(grant),    32'h1);
        check("runrej_d", 32'(rnd_data), 32'hAA);
        tick();
        check("runrej_d2", 32'(rnd_data), 32'hD5);
        req = 4'b0000;
        tick();

        // Period measurement: x^8+x^4+x^3+x^2+1 is a maximal-length polynomial, so the period is 255.
        req       = 4'b0001;
        cfg_valid = 1'b1;
        cfg_taps  = 8'hB8;
        cfg_seed  = 8'hAA;
        tick();
        cfg_valid = 1'b0;
        n_grant = 0;
        n_wrap  = 0;
        wrap_at = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (grant == 4'b0001 && rnd_valid) n_grant++;
            if (wrap) begin
                n_wrap++;
                if (wrap_at == 0) wrap_at = i;
            end
            if (i == 254) begin
                check("per_pl_254",   32'(period_len), 32'd0);
                check("per_wrap_254", 32'(wrap),       32'h0);
            end
            if (i == 255) begin
                check("per_wrap_255", 32'(wrap),       32'h1);
                check("per_pl_255",   32'(period_len), 32'd255);
            end
            if (i == 256) begin
                check("per_d_256",    32'(rnd_data),   32'hAA);
                check("per_wrap_256", 32'(wrap),       32'h0);
            end
        end
        check("per_grants",  32'(n_grant), 32'd300);
        check("per_nwrap",   32'(n_wrap),  32'd1);
        check("per_wrap_at", 32'(wrap_at), 32'd255);
        check("per_pl_end",  32'(period_len), 32'd255);

        // An asynchronous reset in the middle of a cycle clears the outputs before the next edge.
        check("pre_rst_grant", 32'(grant), 32'h1);
        #3;
        in_n_rst = 1'b0;
        #1;
        check("arst_grant",  32'(grant),      32'h0);
        check("arst_valid",  32'(rnd_valid),  32'h0);
        check("arst_cfg",    32'(configured), 32'h0);
        check("arst_pl",     32'(period_len), 32'h0);
        check("arst_data",   32'(rnd_data),   32'h00);
        tick();
        in_n_rst = 1'b1;
        tick();
        tick();
        check("post_rst_grant", 32'(grant),      32'h0);
        check("post_rst_cfg",   32'(configured), 32'h0);
        tick();
        check("post_rst_valid", 32'(rnd_valid),  32'h0);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
